// File: rtl/debounce_pkg.sv
`default_nettype none
//==============================================================================
// Module      : debounce_pkg
// Description : Shared types and constants for the debounce / event arbiter
//               slice: event type encoding, hold-counter width and the
//               channel-index width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package debounce_pkg;

   typedef logic [1:0] evt_type_t;

   localparam evt_type_t EVT_PRESS   = 2'b00;
   localparam evt_type_t EVT_RELEASE = 2'b01;
   localparam evt_type_t EVT_LONG    = 2'b10;

   // Width of the per-channel long-press hold counter.
   localparam int unsigned HOLD_W = 10;

   // Channel index width; a single channel still needs one bit.
   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
//==============================================================================
// Module      : debounce_channel
// Description : One switch channel: two-flop synchroniser, tick-driven
//               stability counter, debounced level and (optionally) a
//               long-press hold counter. Emits a combinational event pulse
//               on the same cycle the debounced level flips, so the parent
//               can load its pending slot on that edge.
// Macro       : DEBOUNCE_LONG_PRESS_EN enables the hold counter and the
//               long-press event.
// Ports       : clk, reset (async, active-high), tick_i (prescaler tick),
//               sw_i (raw switch), db_o (debounced level),
//               evt_pulse_o (event this cycle), evt_type_o (event type)
// Revision    : 1.0 - initial release
//==============================================================================
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = 3,
   parameter int unsigned LP_TICKS     = 100
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      tick_i,
   input  logic      sw_i,
   output logic      db_o,
   output logic      evt_pulse_o,
   output evt_type_t evt_type_o
);

   logic [1:0] sync_q;
   logic       s;
   logic       db_q;
   logic [3:0] cnt_q, cnt_d;
   logic       flip;
   logic       long_hit;

   assign s = sync_q[1];

   // Final tick of a stable difference: level flips on this edge.
   assign flip = tick_i && (s != db_q) && (cnt_q == 4'(STABLE_TICKS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if ((s == db_q) || flip) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         db_q   <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], sw_i};
         cnt_q  <= cnt_d;
         if (flip) begin
            db_q <= ~db_q;
         end
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   logic [HOLD_W-1:0] hold_q, hold_d;

   // Fires on the tick that takes the counter to LP_TICKS; a release on the
   // same tick wins. Saturation keeps it to one event per press.
   assign long_hit = tick_i && db_q && !flip &&
                     (hold_q == HOLD_W'(LP_TICKS - 1));

   always_comb begin
      hold_d = hold_q;
      if (!db_q) begin
         hold_d = '0;
      end else if (tick_i && (hold_q != '1)) begin
         hold_d = hold_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`else
   // No hold counter in this build; LP_TICKS is accepted but has no effect.
   logic unused_lp_ticks;
   assign unused_lp_ticks = ^32'(LP_TICKS);
   assign long_hit        = 1'b0;
`endif

   assign db_o        = db_q;
   assign evt_pulse_o = flip | long_hit;
   assign evt_type_o  = flip ? (db_q ? EVT_RELEASE : EVT_PRESS) : EVT_LONG;

endmodule
`default_nettype wire

// File: rtl/debounce_event_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : debounce_event_arbiter
// Description : Debounces N_CH switches off one shared tick prescaler, turns
//               each debounced edge into a press/release (optionally
//               long-press) event held in a per-channel pending slot, and
//               serialises the slots round-robin onto a valid/ready port.
// Macro       : DEBOUNCE_LONG_PRESS_EN enables long-press events.
// Ports       : clk, reset (async, active-high), sw_i[N_CH] raw switches,
//               db_o[N_CH] debounced levels, evt_valid_o/evt_ready_i
//               handshake, evt_ch_o channel index, evt_type_o event type,
//               evt_drop_o pulse when a pending event is overwritten
// Revision    : 1.0 - initial release
//==============================================================================
module debounce_event_arbiter
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned TICK_BITS    = 19,
   parameter int unsigned STABLE_TICKS = 3,
   parameter int unsigned LP_TICKS     = 100,
   localparam int unsigned CH_W        = ch_width(N_CH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] sw_i,
   output logic [N_CH-1:0] db_o,
   output logic            evt_valid_o,
   input  logic            evt_ready_i,
   output logic [CH_W-1:0] evt_ch_o,
   output evt_type_t       evt_type_o,
   output logic            evt_drop_o
);

   logic [TICK_BITS-1:0]       presc_q;
   logic                       tick;
   logic [N_CH-1:0]            ch_pulse;
   evt_type_t [N_CH-1:0]       ch_type;

   logic [N_CH-1:0]            pend_valid_q, pend_valid_d;
   evt_type_t [N_CH-1:0]       pend_type_q, pend_type_d;
   logic                       drop_any;

   logic                       evt_valid_q;
   logic [CH_W-1:0]            evt_ch_q;
   evt_type_t                  evt_type_q;
   logic                       evt_drop_q;
   logic [CH_W-1:0]            rr_q;

   logic                       free;
   logic                       hit;
   logic [CH_W-1:0]            gnt_idx;
   logic [N_CH-1:0]            gnt;

   assign tick = &presc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + TICK_BITS'(1);
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .LP_TICKS     (LP_TICKS)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .tick_i      (tick),
         .sw_i        (sw_i[g]),
         .db_o        (db_o[g]),
         .evt_pulse_o (ch_pulse[g]),
         .evt_type_o  (ch_type[g])
      );
   end

   // Round-robin search over the registered slots, starting after the last
   // granted channel. Only done when the output register can take a new event.
   always_comb begin
      logic [CH_W-1:0] idx;
      free    = !evt_valid_q || evt_ready_i;
      hit     = 1'b0;
      gnt_idx = rr_q;
      gnt     = '0;
      idx     = '0;
      for (int i = 1; i <= int'(N_CH); i++) begin
         idx = CH_W'((int'(rr_q) + i) % int'(N_CH));
         if (free && !hit && pend_valid_q[idx]) begin
            hit     = 1'b1;
            gnt_idx = idx;
         end
      end
      if (hit) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // A fresh event always takes the slot; it only counts as a drop when the
   // old entry is not leaving through the arbiter on the same edge.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_type_d  = pend_type_q;
      drop_any     = 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
         if (ch_pulse[c]) begin
            if (pend_valid_q[c] && !gnt[c]) begin
               drop_any = 1'b1;
            end
            pend_valid_d[c] = 1'b1;
            pend_type_d[c]  = ch_type[c];
         end else if (gnt[c]) begin
            pend_valid_d[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid_q <= '0;
         pend_type_q  <= '0;
         evt_valid_q  <= 1'b0;
         evt_ch_q     <= '0;
         evt_type_q   <= EVT_PRESS;
         evt_drop_q   <= 1'b0;
         rr_q         <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_type_q  <= pend_type_d;
         evt_drop_q   <= drop_any;
         if (free) begin
            if (hit) begin
               evt_valid_q <= 1'b1;
               evt_ch_q    <= gnt_idx;
               evt_type_q  <= pend_type_q[gnt_idx];
               rr_q        <= gnt_idx;
            end else begin
               evt_valid_q <= 1'b0;
            end
         end
      end
   end

   assign evt_valid_o = evt_valid_q;
   assign evt_ch_o    = evt_ch_q;
   assign evt_type_o  = evt_type_q;
   assign evt_drop_o  = evt_drop_q;

endmodule
`default_nettype wire
